// File: rtl/ground_touch_ctrl.sv
// ground_touch_ctrl: ground ROM addressing, animation tick counter and per-tile sticky touch flags
//   Optional feature macro: GROUND_TOUCH_PULSE_EN adds o_touch_pulse.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     i_col, i_row        current VGA pixel; i_pix_valid marks the visible area
//     i_player_x/y        player hitbox top-left corner
//     i_tile_x/y          three tile top-left corners (10/9-bit fields, tile k at field k)
//     i_game_rst          synchronous clear of all touch state
//     o_ipcnt             free-running counter, wraps after TICK_MAX
//     o_ground            registered ground ROM address for the current pixel
//     o_ground_hit        registered one-hot tile hit for the current pixel
//     o_bk_touched        sticky per-tile touched flags
//     o_touch_pulse       one-cycle pulse when a flag rises (macro only)
module ground_touch_ctrl #(
    parameter int          TILE_W      = 64,
    parameter int          TILE_H      = 64,
    parameter int          PLAYER_W    = 32,
    parameter int          PLAYER_H    = 32,
    parameter int unsigned TICK_MAX    = 6000000,
    parameter int          TOUCH_TICKS = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  i_col,
    input  logic [8:0]  i_row,
    input  logic        i_pix_valid,
    input  logic [9:0]  i_player_x,
    input  logic [8:0]  i_player_y,
    input  logic [29:0] i_tile_x,
    input  logic [26:0] i_tile_y,
    input  logic        i_game_rst,
    output logic [31:0] o_ipcnt,
    output logic [11:0] o_ground,
    output logic [2:0]  o_ground_hit,
    output logic [2:0]  o_bk_touched
`ifdef GROUND_TOUCH_PULSE_EN
    ,
    output logic [2:0]  o_touch_pulse
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_ARMING, S_LATCHED} state_t;

    logic [31:0] r_ipcnt;
    logic [11:0] r_ground;
    logic [2:0]  r_ground_hit;
    logic [2:0]  r_bk_touched;
    logic        w_tick;
    logic [9:0]  w_tx [3];
    logic [8:0]  w_ty [3];
    logic [11:0] w_addr_k [3];
    logic [11:0] w_addr;
    logic [2:0]  w_hit_raw;
    logic [2:0]  w_hit_sel;
    logic [2:0]  w_ovl;
    logic [2:0]  w_latch_nx;
    state_t      r_state [3];
    state_t      w_state_nx [3];
    logic [3:0]  r_cnt [3];
    logic [3:0]  w_cnt_nx [3];

    assign w_tick = (r_ipcnt == TICK_MAX);

    // All edge sums are done at 11 bits so a tile near the screen edge never wraps.
    for (genvar g = 0; g < 3; g++) begin : g_tile
        assign w_tx[g]      = i_tile_x[10*g +: 10];
        assign w_ty[g]      = i_tile_y[9*g +: 9];
        assign w_hit_raw[g] = ({1'b0, i_col} >= {1'b0, w_tx[g]}) &&
                              ({1'b0, i_col} < {1'b0, w_tx[g]} + 11'(TILE_W)) &&
                              ({2'b0, i_row} >= {2'b0, w_ty[g]}) &&
                              ({2'b0, i_row} < {2'b0, w_ty[g]} + 11'(TILE_H));
        assign w_ovl[g]     = ({1'b0, i_player_x} < {1'b0, w_tx[g]} + 11'(TILE_W)) &&
                              ({1'b0, i_player_x} + 11'(PLAYER_W) > {1'b0, w_tx[g]}) &&
                              ({2'b0, i_player_y} < {2'b0, w_ty[g]} + 11'(TILE_H)) &&
                              ({2'b0, i_player_y} + 11'(PLAYER_H) > {2'b0, w_ty[g]});
        assign w_addr_k[g]  = 12'(32'(i_row - w_ty[g]) * 32'(TILE_W) + 32'(i_col - w_tx[g]));
    end

    // Isolate the lowest set bit so overlapping tiles resolve to the lowest index.
    assign w_hit_sel = w_hit_raw & (~w_hit_raw + 3'd1);
    assign w_addr    = w_hit_sel[0] ? w_addr_k[0] :
                       w_hit_sel[1] ? w_addr_k[1] :
                       w_hit_sel[2] ? w_addr_k[2] : 12'd0;

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            w_state_nx[k] = r_state[k];
            w_cnt_nx[k]   = r_cnt[k];
            if (i_game_rst) begin
                w_state_nx[k] = S_IDLE;
                w_cnt_nx[k]   = 4'd0;
            end else if (w_tick) begin
                case (r_state[k])
                    S_IDLE: begin
                        if (w_ovl[k]) begin
                            w_state_nx[k] = (TOUCH_TICKS == 1) ? S_LATCHED : S_ARMING;
                            w_cnt_nx[k]   = 4'd1;
                        end
                    end
                    S_ARMING: begin
                        w_cnt_nx[k]   = w_ovl[k] ? r_cnt[k] + 4'd1 : 4'd0;
                        w_state_nx[k] = !w_ovl[k] ? S_IDLE :
                                        (r_cnt[k] + 4'd1 == 4'(TOUCH_TICKS)) ? S_LATCHED : S_ARMING;
                    end
                    default: ;
                endcase
            end
            w_latch_nx[k] = (w_state_nx[k] == S_LATCHED);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ipcnt      <= '0;
            r_ground     <= '0;
            r_ground_hit <= '0;
            r_bk_touched <= '0;
            for (int k = 0; k < 3; k++) begin
                r_state[k] <= S_IDLE;
                r_cnt[k]   <= '0;
            end
        end else begin
            r_ipcnt      <= w_tick ? '0 : r_ipcnt + 32'd1;
            r_ground     <= i_pix_valid ? w_addr : 12'd0;
            r_ground_hit <= i_pix_valid ? w_hit_sel : 3'd0;
            r_bk_touched <= w_latch_nx;
            for (int k = 0; k < 3; k++) begin
                r_state[k] <= w_state_nx[k];
                r_cnt[k]   <= w_cnt_nx[k];
            end
        end
    end

`ifdef GROUND_TOUCH_PULSE_EN
    logic [2:0] r_touch_pulse;

    // r_bk_touched mirrors "currently LATCHED", so this fires only on entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_touch_pulse <= '0;
        else        r_touch_pulse <= w_latch_nx & ~r_bk_touched;
    end

    assign o_touch_pulse = r_touch_pulse;
`endif

    assign o_ipcnt      = r_ipcnt;
    assign o_ground     = r_ground;
    assign o_ground_hit = r_ground_hit;
    assign o_bk_touched = r_bk_touched;
endmodule

// File: tb/tb_ground_touch_ctrl.sv
// tb_ground_touch_ctrl: directed bench for ground_touch_ctrl (TICK_MAX=9, TOUCH_TICKS=3)
module tb_ground_touch_ctrl;
    localparam logic [9:0] AWX = 10'd800;
    localparam logic [8:0] AWY = 9'd0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  i_col;
    logic [8:0]  i_row;
    logic        i_pix_valid;
    logic [9:0]  i_player_x;
    logic [8:0]  i_player_y;
    logic [29:0] i_tile_x;
    logic [26:0] i_tile_y;
    logic        i_game_rst;
    logic [31:0] o_ipcnt;
    logic [11:0] o_ground;
    logic [2:0]  o_ground_hit;
    logic [2:0]  o_bk_touched;
`ifdef GROUND_TOUCH_PULSE_EN
    logic [2:0]  o_touch_pulse;
`endif

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    typedef struct {
        logic [9:0]  col;
        logic [8:0]  row;
        logic        pv;
        logic [29:0] tx;
        logic [26:0] ty;
        logic [11:0] g;
        logic [2:0]  h;
    } vec_t;

    vec_t vecs [12];

    ground_touch_ctrl #(
        .TICK_MAX    (9),
        .TOUCH_TICKS (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_col        (i_col),
        .i_row        (i_row),
        .i_pix_valid  (i_pix_valid),
        .i_player_x   (i_player_x),
        .i_player_y   (i_player_y),
        .i_tile_x     (i_tile_x),
        .i_tile_y     (i_tile_y),
        .i_game_rst   (i_game_rst),
        .o_ipcnt      (o_ipcnt),
        .o_ground     (o_ground),
        .o_ground_hit (o_ground_hit),
        .o_bk_touched (o_bk_touched)
`ifdef GROUND_TOUCH_PULSE_EN
        ,
        .o_touch_pulse(o_touch_pulse)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        exp_cnt = (exp_cnt == 9) ? 0 : exp_cnt + 1;
        chk("ipcnt", o_ipcnt, 32'(exp_cnt));
    endtask

    // Holds the player away except in the tick cycle, where it is placed at (px,py).
    task automatic tick(input logic [9:0] px, input logic [8:0] py);
        i_player_x = AWX;
        i_player_y = AWY;
        while (exp_cnt != 9) step();
        i_player_x = px;
        i_player_y = py;
        step();
        i_player_x = AWX;
        i_player_y = AWY;
    endtask

    task automatic pulse_chk(input string name, input logic [2:0] exp);
`ifdef GROUND_TOUCH_PULSE_EN
        chk(name, 32'(o_touch_pulse), 32'(exp));
`else
        chk(name, 32'(o_bk_touched & exp), 32'(exp));
`endif
    endtask

    initial begin
        vecs[0]  = '{10'd103, 9'd202, 1'b1, {10'd600, 10'd600, 10'd100}, {9'd400, 9'd400, 9'd200}, 12'd131,  3'b001};
        vecs[1]  = '{10'd164, 9'd202, 1'b1, {10'd600, 10'd600, 10'd100}, {9'd400, 9'd400, 9'd200}, 12'd0,    3'b000};
        vecs[2]  = '{10'd163, 9'd202, 1'b1, {10'd600, 10'd600, 10'd100}, {9'd400, 9'd400, 9'd200}, 12'd191,  3'b001};
        vecs[3]  = '{10'd100, 9'd200, 1'b1, {10'd600, 10'd600, 10'd100}, {9'd400, 9'd400, 9'd200}, 12'd0,    3'b001};
        vecs[4]  = '{10'd103, 9'd202, 1'b0, {10'd600, 10'd600, 10'd100}, {9'd400, 9'd400, 9'd200}, 12'd0,    3'b000};
        vecs[5]  = '{10'd99,  9'd202, 1'b1, {10'd600, 10'd600, 10'd100}, {9'd400, 9'd400, 9'd200}, 12'd0,    3'b000};
        vecs[6]  = '{10'd100, 9'd263, 1'b1, {10'd600, 10'd600, 10'd100}, {9'd400, 9'd400, 9'd200}, 12'd4032, 3'b001};
        vecs[7]  = '{10'd100, 9'd264, 1'b1, {10'd600, 10'd600, 10'd100}, {9'd400, 9'd400, 9'd200}, 12'd0,    3'b000};
        vecs[8]  = '{10'd110, 9'd210, 1'b1, {10'd600, 10'd100, 10'd100}, {9'd400, 9'd200, 9'd200}, 12'd650,  3'b001};
        vecs[9]  = '{10'd305, 9'd101, 1'b1, {10'd600, 10'd300, 10'd100}, {9'd400, 9'd100, 9'd200}, 12'd69,   3'b010};
        vecs[10] = '{10'd563, 9'd363, 1'b1, {10'd500, 10'd600, 10'd100}, {9'd300, 9'd400, 9'd200}, 12'd4095, 3'b100};
        vecs[11] = '{10'd1023, 9'd460, 1'b1, {10'd1000, 10'd600, 10'd100}, {9'd450, 9'd400, 9'd200}, 12'd663, 3'b100};

        rst_n = 1'b0;
        i_col = '0;
        i_row = '0;
        i_pix_valid = 1'b0;
        i_player_x = AWX;
        i_player_y = AWY;
        i_tile_x = {10'd600, 10'd600, 10'd100};
        i_tile_y = {9'd400, 9'd400, 9'd200};
        i_game_rst = 1'b0;
        #7;
        chk("reset ipcnt", o_ipcnt, 0);
        chk("reset ground", 32'(o_ground), 0);
        chk("reset ground_hit", 32'(o_ground_hit), 0);
        chk("reset bk_touched", 32'(o_bk_touched), 0);
        pulse_chk("reset touch_pulse", 3'b000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_cnt = 0;
        chk("ipcnt after release", o_ipcnt, 0);

        // Counter wrap and independence from game_rst
        repeat (12) step();
        i_game_rst = 1'b1;
        step();
        i_game_rst = 1'b0;
        repeat (3) step();

        // Address vectors
        for (int i = 0; i < 12; i++) begin
            i_col = vecs[i].col;
            i_row = vecs[i].row;
            i_pix_valid = vecs[i].pv;
            i_tile_x = vecs[i].tx;
            i_tile_y = vecs[i].ty;
            step();
            chk($sformatf("ground[%0d]", i), 32'(o_ground), 32'(vecs[i].g));
            chk($sformatf("ground_hit[%0d]", i), 32'(o_ground_hit), 32'(vecs[i].h));
        end
        i_pix_valid = 1'b0;

        // Touch tests: tile0 (0,400), tile1 (200,100), tile2 (400,300)
        i_tile_x = {10'd400, 10'd200, 10'd0};
        i_tile_y = {9'd300, 9'd100, 9'd400};
        i_game_rst = 1'b1;
        step();
        i_game_rst = 1'b0;
        chk("bk after game_rst", 32'(o_bk_touched), 0);

        tick(10'd410, 9'd310);
        chk("debounce tick1", 32'(o_bk_touched), 0);
        tick(10'd410, 9'd310);
        chk("debounce tick2", 32'(o_bk_touched), 0);
        tick(10'd410, 9'd310);
        chk("debounce tick3 latch", 32'(o_bk_touched), 32'(3'b100));
        pulse_chk("pulse tile2 rise", 3'b100);
        step();
        pulse_chk("pulse tile2 drop", 3'b000);
        tick(AWX, AWY);
        tick(AWX, AWY);
        chk("sticky after leaving", 32'(o_bk_touched), 32'(3'b100));

        // game_rst coincident with an overlapping tick
        while (exp_cnt != 9) step();
        i_player_x = 10'd410;
        i_player_y = 9'd310;
        i_game_rst = 1'b1;
        step();
        i_game_rst = 1'b0;
        i_player_x = AWX;
        i_player_y = AWY;
        chk("game_rst at tick", 32'(o_bk_touched), 0);
        pulse_chk("no pulse on game_rst", 3'b000);
        tick(10'd410, 9'd310);
        tick(10'd410, 9'd310);
        chk("rearm 2 ticks", 32'(o_bk_touched), 0);
        tick(10'd410, 9'd310);
        chk("rearm 3 ticks", 32'(o_bk_touched), 32'(3'b100));

        // Broken run: two ticks, a miss, then two more must not latch
        i_game_rst = 1'b1;
        step();
        i_game_rst = 1'b0;
        tick(10'd410, 9'd310);
        tick(10'd410, 9'd310);
        tick(AWX, AWY);
        chk("break at tick3", 32'(o_bk_touched), 0);
        tick(10'd410, 9'd310);
        tick(10'd410, 9'd310);
        chk("restart 2 ticks", 32'(o_bk_touched), 0);
        tick(10'd410, 9'd310);
        chk("restart 3 ticks", 32'(o_bk_touched), 32'(3'b100));

        // Overlap boundaries on tile2
        i_game_rst = 1'b1;
        step();
        i_game_rst = 1'b0;
        repeat (3) tick(10'd368, 9'd310);
        chk("touching edge no overlap", 32'(o_bk_touched), 0);
        repeat (3) tick(10'd463, 9'd363);
        chk("corner overlap", 32'(o_bk_touched), 32'(3'b100));

        // Tile1 pulse alignment
        i_game_rst = 1'b1;
        step();
        i_game_rst = 1'b0;
        tick(10'd190, 9'd90);
        tick(10'd190, 9'd90);
        chk("tile1 before latch", 32'(o_bk_touched), 0);
        pulse_chk("tile1 pulse before", 3'b000);
        tick(10'd190, 9'd90);
        chk("tile1 latch", 32'(o_bk_touched), 32'(3'b010));
        pulse_chk("tile1 pulse rise", 3'b010);
        step();
        pulse_chk("tile1 pulse one cycle", 3'b000);
        tick(10'd190, 9'd90);
        pulse_chk("tile1 no repeat pulse", 3'b000);
        chk("tile1 held", 32'(o_bk_touched), 32'(3'b010));

        // rst_n mid-ARMING clears everything asynchronously
        i_game_rst = 1'b1;
        step();
        i_game_rst = 1'b0;
        tick(10'd410, 9'd310);
        i_col = 10'd410;
        i_row = 9'd310;
        i_pix_valid = 1'b1;
        step();
        chk("ground before reset", 32'(o_ground), 32'(10 * 64 + 10));
        rst_n = 1'b0;
        #2;
        chk("async rst ipcnt", o_ipcnt, 0);
        chk("async rst ground", 32'(o_ground), 0);
        chk("async rst ground_hit", 32'(o_ground_hit), 0);
        chk("async rst bk", 32'(o_bk_touched), 0);
        i_pix_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_cnt = 0;
        tick(10'd410, 9'd310);
        tick(10'd410, 9'd310);
        chk("arming cleared by rst_n", 32'(o_bk_touched), 0);
        tick(10'd410, 9'd310);
        chk("latch after rst_n", 32'(o_bk_touched), 32'(3'b100));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ground_touch_ctrl.md
Name: ground_touch_ctrl

Overview:
- Drives the ground display path: pixel-to-ROM address generation, the animation tick counter, and per-tile sticky touch flags.
- Its outputs (ipcnt, ground, bk_touched) feed the ground frame-animation/display modules, one instance per three ground tiles.
- Sits between VGA timing, player position logic and the ground display path.

Parameters:
- TILE_W, 64: tile width in pixels; TILE_W*TILE_H must be at most 4096.
- TILE_H, 64: tile height in pixels.
- PLAYER_W, 32: player hitbox width.
- PLAYER_H, 32: player hitbox height.
- TICK_MAX, 6000000: ipcnt terminal value; a tick is any cycle with ipcnt==TICK_MAX.
- TOUCH_TICKS, 3: consecutive overlapping ticks needed to latch a touch; legal range 1..15.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- col  in  10  current VGA pixel x
- row  in  9  current VGA pixel y
- pix_valid  in  1  col/row in visible area
- player_x  in  10  player hitbox left edge
- player_y  in  9  player hitbox top edge
- tile_x  in  30  tile k left edge at [10k+9:10k], k=0..2
- tile_y  in  27  tile k top edge at [9k+8:9k]
- game_rst  in  1  synchronous clear of touch state (level restart)
- ipcnt  out  32  free-running tick counter
- ground  out  12  ground ROM address for current pixel
- ground_hit  out  3  one-hot: current pixel lies in tile k
- bk_touched  out  3  sticky per-tile touched flags

Behaviour:
- Reset: asynchronous, active-low. While rst_n=0, ipcnt=0, ground=0, ground_hit=0, bk_touched=0, and all tile FSMs are IDLE.
- ipcnt:
  - Increments by 1 each cycle.
  - At TICK_MAX, the next value is 0, so the period is TICK_MAX+1 cycles.
  - Unaffected by game_rst.
- Pixel hit: tile k hits when tx_k <= col < tx_k+TILE_W and ty_k <= row < ty_k+TILE_H. Sums are computed at 11 bits, so there is no wrap.
  - Overlapping tiles: the lowest index wins, and ground_hit stays one-hot.
- Address output (registered, 1-cycle latency):
  - With pix_valid=1 and a hit on tile k: ground <= (row-ty_k)*TILE_W + (col-tx_k), truncated to 12 bits; ground_hit <= one-hot(k).
  - Otherwise: ground <= 0 and ground_hit <= 0.
- Overlap test for tile k (11-bit compare): player_x < tx_k+TILE_W, player_x+PLAYER_W > tx_k, player_y < ty_k+TILE_H, and player_y+PLAYER_H > ty_k.
- Per-tile FSM: states IDLE, ARMING, LATCHED, plus a 4-bit counter cnt. It is evaluated only on tick cycles.
  - IDLE:
    - Overlap at a tick with TOUCH_TICKS=1 -> LATCHED.
    - Overlap at a tick otherwise -> ARMING, cnt=1.
  - ARMING:
    - Overlap at a tick: cnt+1. When cnt+1==TOUCH_TICKS -> LATCHED.
    - No overlap at a tick -> IDLE, cnt=0.
  - LATCHED: held regardless of overlap until game_rst or reset.
  - bk_touched[k] is registered: it is 1 in the cycle after the transition into LATCHED, and stays 1 while the FSM is LATCHED.
- game_rst=1: all FSMs go to IDLE, cnt=0 and bk_touched=0 on the next edge.
  - game_rst and a tick in the same cycle: game_rst wins, and that tick is ignored.
- Player positions between ticks are ignored; only the tick-cycle sample counts.

Optional Feature:
- Macro: GROUND_TOUCH_PULSE_EN.
- Defined: adds output port touch_pulse, 3 bits, reset 0. touch_pulse[k] is a 1-cycle pulse asserted on the same edge that bk_touched[k] rises. It never fires while the tile remains LATCHED, and does not fire on game_rst.
- Undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Counter wrap, with TICK_MAX=9: release reset -> ipcnt runs 0..9, then 0; period 10 cycles. A game_rst pulse leaves ipcnt unchanged.
- Address:
  - Setup: tile0 at (100,200), pix_valid=1.
  - col=103,row=202 -> next cycle ground=2*64+3=131, ground_hit=3'b001.
  - col=164 -> ground=0, ground_hit=0.
  - pix_valid=0 -> ground=0.
- Overlap priority: tile0 and tile1 both at (100,200), pixel (110,210) -> ground_hit=3'b001.
- Touch debounce (TOUCH_TICKS=3, TICK_MAX=9):
  - Player overlaps tile2 for 3 ticks -> bk_touched=3'b100 one cycle after the 3rd tick.
  - Overlap for 2 ticks, then none at the 3rd -> flag stays 0.
  - Once latched, moving the player away keeps it at 1.
- game_rst:
  - Latched tile with game_rst=1 coincident with a tick while overlapping -> bk_touched=0 next cycle.
  - Rearm then needs 3 fresh ticks.
  - rst_n low mid-ARMING clears everything immediately.
- GROUND_TOUCH_PULSE_EN:
  - touch_pulse[1] is high for exactly one cycle, aligned with the bk_touched[1] rise.
  - No further pulses while LATCHED.
  - With the macro undefined, the bench compiles without the port.
